ldpc_mlgd_decoder: RTL
======================

LDPC_MLGD_DECODER -- requirements
Module: ldpc_mlgd_decoder

Interface
REQ-001 SHALL have parameter N, default 256, meaning code length in bits.
REQ-002 SHALL have parameter M, default 128, meaning number of parity checks (rows of H).
REQ-003 SHALL have parameter MAX_ITER, default 10, meaning maximum flip iterations (0 allowed).
REQ-004 SHALL have parameter H_MATRIX, default all-zero, meaning M*N-bit parity-check matrix; row m occupies bits [m*N +: N].
REQ-005 SHALL have parameter FLIP_MODE, default 0, meaning 0 = strict majority (2*wrong > colweight), 1 = fixed threshold (wrong >= FLIP_TH).
REQ-006 SHALL have parameter FLIP_TH, default 1, meaning flip threshold used when FLIP_MODE=1.
REQ-007 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-009 SHALL have port work  input  1  start request; sampled only while free=1.
REQ-010 SHALL have port tx  input  N  received hard-decision word, captured on accepted work.
REQ-011 SHALL have port free  output  1  high when idle and able to accept work.
REQ-012 SHALL have port deout  output  N  decoded word; holds until next valid.
REQ-013 SHALL have port valid  output  1  one-cycle pulse marking deout/success/iter_used updated.
REQ-014 SHALL have port success  output  1  1 = final syndrome all-zero; 0 = gave up.
REQ-015 SHALL have port iter_used  output  clog2(MAX_ITER+1), min 1  iterations performed for the reported word.

Function
REQ-016 SHALL implement states IDLE, SYND, EVAL, CNT, FLIP.
REQ-017 IDLE: free=1; on work=1 SHALL latch tx into working word, clear iteration counter, drop free, go SYND.
REQ-018 work while free=0 SHALL be ignored; no queuing.
REQ-019 SYND SHALL register syndrome s[m] = XOR over j of (H[m][j] & word[j]), go EVAL.
REQ-020 EVAL: s==0 SHALL finish with success=1; else iter==MAX_ITER SHALL finish with success=0; else go CNT.
REQ-021 CNT SHALL register per-bit wrong[j] = count of m with H[m][j]=1 and s[m]=1, width clog2(M+1).
REQ-022 colweight[j] SHALL be an elaboration-time constant derived from H_MATRIX, not a register.
REQ-023 FLIP SHALL invert every bit meeting the FLIP_MODE criterion simultaneously, increment iter, go SYND.
REQ-024 bits with colweight 0 SHALL never flip.
REQ-025 stall: if FLIP finds no bit to flip, SHALL finish immediately with success=0, iter counted.
REQ-026 finish SHALL in one edge load deout=word, success, iter_used, pulse valid=1, set free=1, return IDLE.
REQ-027 latency from accepting edge to valid edge SHALL be 2 + 4*I cycles, I = iterations run (stall finish: 4*I+1).
REQ-028 work may be reasserted in the cycle valid is high; a new accept SHALL occur no earlier than the edge after valid.
REQ-029 arithmetic SHALL be unsigned; the 2*wrong comparison SHALL be carried at width+1 without overflow.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, free=1, valid=0, success=0, iter_used=0, deout=0, working word=0.
REQ-031 reset mid-decode SHALL abort with no valid pulse; first accept is possible on the first edge after release.

Structure
REQ-032 state encoding, FLIP_MODE codes and width helper (clog2) SHALL live in shared package ldpc_pkg.
REQ-033 syndrome/count network SHALL be sub-module ldpc_syndrome_unit (inputs word, H param; outputs s, wrong[]); control FSM stays in top.
REQ-034 target size 120-400 RTL lines; no memories, all H logic elaborated from parameters.

Verification (bench: N=15, M=15 cyclic (15,7) difference-set H, colweight 4, MAX_ITER=4, FLIP_MODE=0)
REQ-035 all-zero tx, work=1 -> valid 2 cycles after accept, deout=0, success=1, iter_used=0.
REQ-036 tx=15'h0020 (single error bit5) -> valid 6 cycles after accept, deout=0, success=1, iter_used=1.
REQ-037 tx=15'h0021 (two errors) -> deout=0, success=1, iter_used=1; then MAX_ITER=0 rerun -> success=0, deout=15'h0021, valid at 2 cycles.
REQ-038 work pulsed every cycle during a decode -> exactly one valid per accepted word, second tx ignored until free=1.
REQ-039 rst low mid-CNT -> free=1, valid=0, deout=0 immediately; next all-zero decode behaves as REQ-035.
REQ-040 FLIP_MODE=1, FLIP_TH=5 with single error -> stall finish, success=0, iter_used=1, deout=tx, valid at 5 cycles.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC majority-logic bit-flip decoder.
//   state_t      : control FSM encoding
//   FLIP_*       : FLIP_MODE parameter codes
//   clog2_min1() : ceil(log2(v)) but never below 1, so counters stay at least 1 bit wide
package ldpc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYND = 3'd1,
    EVAL = 3'd2,
    CNT  = 3'd3,
    FLIP = 3'd4
  } state_t;

  localparam int FLIP_MAJORITY = 0;  // flip when 2*wrong > colweight
  localparam int FLIP_THRESH   = 1;  // flip when wrong >= FLIP_TH

  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ldpc_mlgd_decoder_if.sv
// Request/response bundle of the LDPC decoder.
//   work/tx              : start request and received hard-decision word
//   free                 : decoder idle, work will be accepted
//   valid                : one-cycle pulse, deout/success/iter_used just updated
//   deout/success/iter_used : decode result, held until the next valid
// master = requester side, slave = decoder side.
interface ldpc_mlgd_decoder_if #(
  parameter int N  = 256,
  parameter int IW = 4
);
  logic          work;
  logic [N-1:0]  tx;
  logic          free;
  logic [N-1:0]  deout;
  logic          valid;
  logic          success;
  logic [IW-1:0] iter_used;

  modport master (output work, tx, input free, deout, valid, success, iter_used);
  modport slave  (input work, tx, output free, deout, valid, success, iter_used);
endinterface

// File: rtl/ldpc_syndrome_unit.sv
// Parity network of the decoder, fully elaborated from H_MATRIX.
//   word   : current working word            -> synd  : per-check parity (combinational)
//   synd_q : registered syndrome             -> wrong : per-bit count of failing checks
// The per-bit counters live in ldpc_bit_node, one instance per code bit.
module ldpc_bit_node #(
  parameter int           M   = 128,
  parameter int           CW  = 8,
  parameter logic [M-1:0] COL = '0   // column of H for this bit
) (
  input  logic [M-1:0]  synd_q,
  output logic [CW-1:0] wrong
);
  always_comb begin
    wrong = '0;
    for (int m = 0; m < M; m++)
      if (COL[m]) wrong = wrong + CW'(synd_q[m]);
  end
endmodule

module ldpc_syndrome_unit #(
  parameter int             N        = 256,
  parameter int             M        = 128,
  parameter int             CW       = 8,
  parameter logic [M*N-1:0] H_MATRIX = '0
) (
  input  logic [N-1:0]         word,
  input  logic [M-1:0]         synd_q,
  output logic [M-1:0]         synd,
  output logic [N-1:0][CW-1:0] wrong
);
  function automatic logic [M-1:0] col_bits(input int j);
    logic [M-1:0] c;
    c = '0;
    for (int m = 0; m < M; m++) c[m] = H_MATRIX[m*N + j];
    return c;
  endfunction

  for (genvar m = 0; m < M; m++) begin : g_chk
    assign synd[m] = ^(H_MATRIX[m*N +: N] & word);
  end

  for (genvar j = 0; j < N; j++) begin : g_bit
    ldpc_bit_node #(.M(M), .CW(CW), .COL(col_bits(j))) u_node (
      .synd_q (synd_q),
      .wrong  (wrong[j])
    );
  end
endmodule

// File: rtl/ldpc_mlgd_decoder.sv
// Iterative majority-logic (bit-flip) LDPC hard-decision decoder.
//   clk, rst (async, active low)
//   bus (slave): work/tx in, free/deout/valid/success/iter_used out
// One word at a time: IDLE -> SYND -> EVAL -> (CNT -> FLIP -> SYND -> EVAL)* -> IDLE.
// All bits meeting the flip criterion are inverted together in FLIP.
module ldpc_mlgd_decoder
  import ldpc_pkg::*;
#(
  parameter int             N         = 256,
  parameter int             M         = 128,
  parameter int             MAX_ITER  = 10,
  parameter logic [M*N-1:0] H_MATRIX  = '0,
  parameter int             FLIP_MODE = 0,
  parameter int             FLIP_TH   = 1
) (
  input  logic          clk,
  input  logic          rst,
  ldpc_mlgd_decoder_if.slave bus
);
  localparam int CW = clog2_min1(M + 1);
  localparam int IW = clog2_min1(MAX_ITER + 1);

  function automatic int col_weight(input int j);
    int w;
    w = 0;
    for (int m = 0; m < M; m++) w += int'(H_MATRIX[m*N + j]);
    return w;
  endfunction

  state_t                state_q, state_d;
  logic [N-1:0]          word_q;
  logic [M-1:0]          synd_q, synd;
  logic [N-1:0][CW-1:0]  wrong_q, wrong;
  logic [IW-1:0]         iter_q;
  logic                  stall_q;
  logic [N-1:0]          deout_q;
  logic                  success_q, valid_q;
  logic [IW-1:0]         iter_used_q;
  logic [N-1:0]          flip_mask;

  logic accept, finish, fin_ok, ld_synd, ld_wrong, do_flip;

  ldpc_syndrome_unit #(.N(N), .M(M), .CW(CW), .H_MATRIX(H_MATRIX)) u_synd (
    .word   (word_q),
    .synd_q (synd_q),
    .synd   (synd),
    .wrong  (wrong)
  );

  // Flip criterion per bit. Majority compares 2*wrong against the column
  // weight one bit wider than the counter so the doubling cannot wrap.
  for (genvar j = 0; j < N; j++) begin : g_flip
    localparam int CWT = col_weight(j);
    logic maj, thr;
    assign maj = {wrong_q[j], 1'b0} > (CW+1)'(CWT);
    assign thr = 32'(wrong_q[j]) >= $unsigned(FLIP_TH);
    assign flip_mask[j] = (CWT != 0) && ((FLIP_MODE == FLIP_MAJORITY) ? maj : thr);
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    finish   = 1'b0;
    fin_ok   = 1'b0;
    ld_synd  = 1'b0;
    ld_wrong = 1'b0;
    do_flip  = 1'b0;
    case (state_q)
      IDLE: if (bus.work) begin
        accept  = 1'b1;
        state_d = SYND;
      end
      // A FLIP that changed nothing is reported here rather than in FLIP
      // itself, so the wide OR over flip_mask is registered first.
      SYND: if (stall_q) begin
        finish  = 1'b1;
        state_d = IDLE;
      end else begin
        ld_synd = 1'b1;
        state_d = EVAL;
      end
      EVAL: if (synd_q == '0) begin
        finish  = 1'b1;
        fin_ok  = 1'b1;
        state_d = IDLE;
      end else if (iter_q == IW'(MAX_ITER)) begin
        finish  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = CNT;
      end
      CNT: begin
        ld_wrong = 1'b1;
        state_d  = FLIP;
      end
      FLIP: begin
        do_flip = 1'b1;
        state_d = SYND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      synd_q      <= '0;
      wrong_q     <= '0;
      iter_q      <= '0;
      stall_q     <= 1'b0;
      deout_q     <= '0;
      success_q   <= 1'b0;
      iter_used_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= finish;
      if (accept) begin
        word_q  <= bus.tx;
        iter_q  <= '0;
        stall_q <= 1'b0;
      end
      if (ld_synd)  synd_q  <= synd;
      if (ld_wrong) wrong_q <= wrong;
      if (do_flip) begin
        word_q  <= word_q ^ flip_mask;
        iter_q  <= iter_q + IW'(1);
        stall_q <= ~|flip_mask;
      end
      if (finish) begin
        deout_q     <= word_q;
        success_q   <= fin_ok;
        iter_used_q <= iter_q;
      end
    end
  end

  assign bus.free      = (state_q == IDLE);
  assign bus.deout     = deout_q;
  assign bus.valid     = valid_q;
  assign bus.success   = success_q;
  assign bus.iter_used = iter_used_q;

endmodule
